bcd_counter_2digit: RTL
=======================

Name: bcd_counter_2digit

Overview:
- Two-digit synchronous BCD up/down counter (00–99). Sits directly upstream of the BCD-to-decimal decoder stage.
- The ones-digit output bits drive the decoder's A0..A3 inputs directly: bit 0 goes to A0, bit 3 goes to A3.
- The tens digit is available for a second decoder instance.
- Supports parallel load, count enable with a programmable prescaler, wrap-around carry/borrow pulse and a load-error flag.

Parameters:
- DIV, 1, clock-enable prescale ratio. The counter steps once every DIV cycles while en=1. Legal range 1..65535.
- PW, 16, prescaler register width. Must satisfy 2^PW ≥ DIV.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; also gates the prescaler.
- up  input  1  direction: 1 = increment, 0 = decrement. Sampled on the stepping edge.
- load  input  1  parallel-load strobe.
- din_ones  input  4  BCD ones digit to load.
- din_tens  input  4  BCD tens digit to load.
- bcd_ones  output  4  registered ones digit (0–9).
- bcd_tens  output  4  registered tens digit (0–9).
- tc  output  1  one-cycle terminal-count pulse on wrap.
- zero  output  1  high while count = 00.
- load_err  output  1  one-cycle pulse on a rejected load.

Behaviour:
- Reset: synchronous, active-high. On a clk edge with rst=1:
  - bcd_ones=0, bcd_tens=0, tc=0, load_err=0, prescaler=0.
  - zero=1 (it follows the count).
  - rst overrides load and en in the same cycle.
  - Reset mid-count or mid-prescale discards all progress.
- Priority per edge: rst > load > count step > hold.
- Load (load=1, rst=0):
  - Valid load (din_ones ≤ 9 and din_tens ≤ 9): digits take the din values on that edge. Prescaler clears to 0, tc=0.
  - Invalid load (either digit in 10–15): digits hold, prescaler holds, load_err=1 for exactly one cycle.
  - load overrides a coincident step. No step occurs on a load edge, whether valid or invalid.
- Prescaler:
  - Counts 0..DIV-1 only while en=1 and load=0. Holds its value while en=0.
  - A step occurs on the edge where prescaler = DIV-1 and en=1. The prescaler returns to 0 on that edge.
  - With DIV=1, every enabled edge is a step.
- Step, up=1:
  - ones 0→8 increments; ones 9→0 with tens+1.
  - 99→00 wraps, and tc=1 in the cycle the outputs first show 00.
- Step, up=0:
  - ones 9→1 decrements; ones 0→9 with tens−1.
  - 00→99 wraps, and tc=1 in the cycle the outputs first show 99.
- tc:
  - Registered, one cycle wide, and cleared on every other edge.
  - Never asserts on load or reset.
  - Direction changes take effect on the next step only.
- zero: derived from the registered digits (count = 00). No extra latency relative to the digit outputs.
- Digit invariant: bcd_ones and bcd_tens never leave 0–9 under any input sequence.
- Latency: digit outputs change on the same edge as the step or load decision. No pipeline.

Test Plan:
- Reset and prescale: rst=1 for 2 cycles, then en=1, up=1, DIV=4, 40 cycles.
  - Expect 00, zero=1 out of reset.
  - Count advances every 4th edge and reaches 10 after 40 edges.
  - Ones sequence 0..9 seen on bcd_ones bits.
- Up wrap: load 98, DIV=1, en=1, up=1, 3 cycles.
  - Expect 99, then 00 with tc=1 for one cycle and zero=1, then 01 with tc=0.
- Down wrap and borrow: load 10, up=0, 3 steps.
  - Expect 09, then 08, then 07.
  - Then load 00 and step once: expect 99 with tc=1.
- Invalid load: count at 42, load=1 with din_tens=3, din_ones=12.
  - Expect count holds 42, load_err=1 for one cycle, no tc.
  - Next valid load of 57 yields 57, load_err=0.
- Collisions: load=1 (value 25) and a step due on the same edge → count = 25, no increment.
- Collisions: rst=1 with load=1 → count = 00.
- Collisions: en dropped mid-prescale for 5 cycles → prescaler holds, and the step lands DIV−k enabled cycles after en is re-raised, where k is the prescaler value at the drop.

Source files
------------

// File: rtl/bcd_counter_2digit.sv
// Two-digit synchronous BCD up/down counter (00-99) with parallel load,
// prescaled count enable, wrap pulse on tc and a rejected-load pulse on load_err.
module bcd_counter_2digit #(
    parameter int unsigned DIV = 1,
    parameter int unsigned PW  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] din_ones,
    input  logic [3:0] din_tens,
    output logic [3:0] bcd_ones,
    output logic [3:0] bcd_tens,
    output logic       tc,
    output logic       zero,
    output logic       load_err
);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc;
    logic          din_ok;
    logic          presc_done;
    logic [3:0]    nxt_ones;
    logic [3:0]    nxt_tens;
    logic          wrap;

    assign din_ok     = (din_ones <= 4'd9) && (din_tens <= 4'd9);
    assign presc_done = (presc == PRESC_LAST);
    assign zero       = (bcd_ones == 4'd0) && (bcd_tens == 4'd0);

    // Next count value one step away in the current direction.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        nxt_ones = bcd_ones;
        nxt_tens = bcd_tens;
        wrap     = 1'b0;
        if (up) begin
            if (bcd_ones == 4'd9) begin
                nxt_ones = 4'd0;
                if (bcd_tens == 4'd9) begin
                    nxt_tens = 4'd0;
                    wrap     = 1'b1;
                end else begin
                    nxt_tens = bcd_tens + 4'd1;
                end
            end else begin
                nxt_ones = bcd_ones + 4'd1;
            end
        end else begin
            if (bcd_ones == 4'd0) begin
                nxt_ones = 4'd9;
                if (bcd_tens == 4'd0) begin
                    nxt_tens = 4'd9;
                    wrap     = 1'b1;
                end else begin
                    nxt_tens = bcd_tens - 4'd1;
                end
            end else begin
                nxt_ones = bcd_ones - 4'd1;
            end
        end
    end

    // Priority per edge: rst > load > prescaled step > hold.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            bcd_ones <= 4'd0;
            bcd_tens <= 4'd0;
            presc    <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tc       <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (din_ok) begin
                    bcd_ones <= din_ones;
                    bcd_tens <= din_tens;
                    presc    <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (presc_done) begin
                    presc    <= '0;
                    bcd_ones <= nxt_ones;
                    bcd_tens <= nxt_tens;
                    tc       <= wrap;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule
